packet_fifo: RTL and testbench
==============================

// Module: packet_fifo
// PURPOSE
//  Elastic 64-bit AXI-Stream FIFO between stream_adapter (UART packets) and stream_arbiter input 0.
//  The UART side cannot stall, so the block absorbs arbiter back-pressure while the scheduler stream holds the merger.
//  Registered first-word-fall-through output; reports occupancy and a high-water flag.
// PARAMETERS
//  DATA_W    64  tdata width in bits; tlast is stored alongside as bit DATA_W.
//  DEPTH     16  memory entries; power of two, >= 2. Total capacity is DEPTH+1 (memory + output register).
//  HI_WATER  12  level (0..DEPTH+1) at or above which o_almost_full asserts.
// PORTS
//  i_clk            in   1            system clock, 100 MHz
//  i_rst            in   1            asynchronous, active-high reset
//  i_s_axis_tdata   in   DATA_W       write beat data
//  i_s_axis_tvalid  in   1            write beat valid
//  i_s_axis_tlast   in   1            write beat last
//  o_s_axis_tready  out  1            1 = a beat is accepted this cycle
//  o_m_axis_tdata   out  DATA_W       head-of-queue data (output register)
//  o_m_axis_tvalid  out  1            output register holds a beat
//  o_m_axis_tlast   out  1            head-of-queue last
//  i_m_axis_tready  in   1            downstream accepts head beat
//  o_level          out  clog2(DEPTH+2)  beats held, memory + output register
//  o_almost_full    out  1            o_level >= HI_WATER
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers 0, o_level 0, o_m_axis_tvalid 0, tdata/tlast 0,
//    o_s_axis_tready 0 while i_rst high, o_almost_full 0.
//  - Accept on i_s_axis_tvalid & o_s_axis_tready; pop on o_m_axis_tvalid & i_m_axis_tready.
//  - o_s_axis_tready = !(memory full) and not in reset; registered, no comb path from i_m_axis_tready.
//    A pop in the same cycle as memory-full does NOT raise tready that cycle; it rises on the next cycle.
//  - Pointers: ADDR_W+1 bits (wrap bit); empty = ptrs equal; full = addresses equal, wrap bits differ.
//  - Output register loads from memory head when (!o_m_axis_tvalid | pop) and memory is non-empty.
//  - Bypass: beat written to an empty memory while output reg empty or popping: tvalid rises 1 cycle
//    after the accept (latency 1). No combinational in->out path.
//  - Steady state: one accept and one pop per cycle sustain 100% throughput, level unchanged.
//  - Memory empty and output reg empty with no accept: tvalid falls after the pop cycle.
//  - o_m_axis_tdata/tlast stable while tvalid & !tready (AXI rule); never change mid-stall.
//  - o_level: +1 on accept only, -1 on pop only, unchanged on both; saturates at DEPTH+1.
//  - tlast is carried verbatim; the block does not interpret packets.
//  - i_rst mid-stream discards all contents; no partial packet is replayed.
// CONFIGURATION
//  PACKET_FIFO_DROP_CNT_EN defined: adds output o_drop_count (16 bits, reset 0). Increments each cycle
//    i_s_axis_tvalid & !o_s_axis_tready; saturates at 16'hFFFF; intended for o_led debug.
//  Not defined: port absent, no counter logic; the refused beat is lost silently.
// STRUCTURE
//  - packet_pkg: PKT_DATA_W=64, beat struct {tlast, tdata}, clog2 helper.
//  - Sub-module packet_fifo_mem: simple dual-port RAM, DEPTH x (DATA_W+1), sync write, sync read;
//    read-enable driven by the output-register load condition (maps to LUTRAM/BRAM).
//  - Top: pointer/flag logic, output register, level counter, optional drop counter.
// TESTING
//  1. Reset: assert i_rst mid-cycle -> all outputs 0 immediately; release -> tready=1 next cycle, level=0.
//  2. Single beat: write 64'h0000_0000_0000_0901 tlast=1, ready=1 -> tvalid next cycle with same
//     data/last, level 1 then 0 after pop.
//  3. Fill: ready=0, write 17 beats 0..16 with DEPTH=16 -> tready falls after 17th accept, level=17,
//     almost_full=1 from level 12; 18th beat refused; drain order 0..16.
//  4. Streaming: ready=1, 100 back-to-back beats -> 100 beats out in order, no bubble after first,
//     level stays at 1.
//  5. Stall stability: ready toggles pseudo-randomly 0/1 -> tdata/tlast never change while tvalid&!tready;
//     scoreboard matches input order.
//  6. With PACKET_FIFO_DROP_CNT_EN: full FIFO, tvalid held 5 cycles -> o_drop_count=5; reset -> 0.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared types and helpers for the packet FIFO slice.
package packet_pkg;

    localparam int unsigned PKT_DATA_W = 64;

    typedef struct packed {
        logic                  tlast;
        logic [PKT_DATA_W-1:0] tdata;
    } beat_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/packet_fifo_mem.sv
// Dual-port beat storage: synchronous write, registered read. The read register doubles as the
// FIFO output register and can capture the write data directly when the FIFO is empty.
module packet_fifo_mem
    import packet_pkg::*;
#(
    parameter int unsigned WIDTH = PKT_DATA_W + 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    input  logic                    i_rd_byp,
    input  logic [clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_byp ? i_wr_data : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/packet_fifo.sv
// Elastic AXI-Stream FIFO with registered first-word-fall-through output and occupancy flags.
// Define PACKET_FIFO_DROP_CNT_EN to add a saturating count of refused beats (o_drop_count).
module packet_fifo
    import packet_pkg::*;
#(
    parameter int unsigned DATA_W   = PKT_DATA_W,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HI_WATER = 12
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_W-1:0]           i_s_axis_tdata,
    input  logic                        i_s_axis_tvalid,
    input  logic                        i_s_axis_tlast,
    output logic                        o_s_axis_tready,
    output logic [DATA_W-1:0]           o_m_axis_tdata,
    output logic                        o_m_axis_tvalid,
    output logic                        o_m_axis_tlast,
    input  logic                        i_m_axis_tready,
    output logic [clog2(DEPTH+2)-1:0]   o_level,
    output logic                        o_almost_full
`ifdef PACKET_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                 o_drop_count
`endif
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned LVL_W  = clog2(DEPTH + 2);
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(DEPTH + 1);
    localparam logic [LVL_W-1:0]  LVL_HI  = LVL_W'(HI_WATER);
    localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);
    localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_m_valid;
    logic              r_s_ready;
    logic [LVL_W-1:0]  r_level;
    logic              r_almost_full;

    logic              w_accept;
    logic              w_pop;
    logic              w_mem_empty;
    logic              w_out_free;
    logic              w_byp;
    logic              w_load;
    logic              w_wr_en;
    logic              w_rd_adv;
    logic [ADDR_W:0]   w_wr_ptr_d;
    logic [ADDR_W:0]   w_rd_ptr_d;
    logic              w_full_d;
    logic [LVL_W-1:0]  w_level_d;
    logic [DATA_W:0]   w_rd_data;

    assign w_accept    = i_s_axis_tvalid & r_s_ready;
    assign w_pop       = r_m_valid & i_m_axis_tready;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_out_free  = ~r_m_valid | w_pop;
    // An accepted beat skips memory when nothing is queued ahead of it.
    assign w_byp       = w_out_free & w_mem_empty & w_accept;
    assign w_load      = w_out_free & (~w_mem_empty | w_accept);
    assign w_wr_en     = w_accept & ~w_byp;
    assign w_rd_adv    = w_out_free & ~w_mem_empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        if (w_wr_en) begin
            w_wr_ptr_d = r_wr_ptr + PTR_ONE;
        end
        if (w_rd_adv) begin
            w_rd_ptr_d = r_rd_ptr + PTR_ONE;
        end
        w_full_d = (w_wr_ptr_d[ADDR_W] != w_rd_ptr_d[ADDR_W]) &&
                   (w_wr_ptr_d[ADDR_W-1:0] == w_rd_ptr_d[ADDR_W-1:0]);
    end

    always_comb begin
        w_level_d = r_level;
        if (w_accept && !w_pop && r_level != LVL_MAX) begin
            w_level_d = r_level + LVL_ONE;
        end else if (!w_accept && w_pop && r_level != '0) begin
            w_level_d = r_level - LVL_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_m_valid     <= 1'b0;
            r_s_ready     <= 1'b0;
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_d;
            r_rd_ptr      <= w_rd_ptr_d;
            r_s_ready     <= ~w_full_d;
            r_level       <= w_level_d;
            r_almost_full <= (w_level_d >= LVL_HI);
            if (w_load) begin
                r_m_valid <= 1'b1;
            end else if (w_pop) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    packet_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data ({i_s_axis_tlast, i_s_axis_tdata}),
        .i_rd_en   (w_load),
        .i_rd_byp  (w_mem_empty),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

`ifdef PACKET_FIFO_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_count <= '0;
        end else if (i_s_axis_tvalid && !r_s_ready && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

    assign o_s_axis_tready = r_s_ready;
    assign o_m_axis_tvalid = r_m_valid;
    assign o_m_axis_tdata  = w_rd_data[DATA_W-1:0];
    assign o_m_axis_tlast  = w_rd_data[DATA_W];
    assign o_level         = r_level;
    assign o_almost_full   = r_almost_full;

endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: directed and random traffic checked against a queue model of the FIFO.
module tb_packet_fifo;
    import packet_pkg::*;

    localparam int CAP = 17;
    localparam int HI  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic [4:0]  level;
    logic        almost_full;
`ifdef PACKET_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    beat_t model[$];
    bit    ready_ok = 1'b0;

    packet_fifo #(
        .DATA_W   (64),
        .DEPTH    (16),
        .HI_WATER (HI)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_s_axis_tdata  (s_tdata),
        .i_s_axis_tvalid (s_tvalid),
        .i_s_axis_tlast  (s_tlast),
        .o_s_axis_tready (s_tready),
        .o_m_axis_tdata  (m_tdata),
        .o_m_axis_tvalid (m_tvalid),
        .o_m_axis_tlast  (m_tlast),
        .i_m_axis_tready (m_tready),
        .o_level         (level),
        .o_almost_full   (almost_full)
`ifdef PACKET_FIFO_DROP_CNT_EN
        ,
        .o_drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the queue model says the FIFO should present.
    task automatic check_model(input string tag);
        bit exp_valid;
        bit exp_ready;
        exp_valid = (model.size() > 0);
        exp_ready = ready_ok && (model.size() < CAP);
        chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(exp_valid));
        chk({tag, "_tready"}, 64'(s_tready), 64'(exp_ready));
        chk({tag, "_level"}, 64'(level), 64'(model.size()));
        chk({tag, "_afull"}, 64'(almost_full), 64'(model.size() >= HI));
        if (exp_valid) begin
            chk({tag, "_tdata"}, m_tdata, model[0].tdata);
            chk({tag, "_tlast"}, 64'(m_tlast), 64'(model[0].tlast));
        end
    endtask

    // Entered and left at posedge+1: drive, check at negedge, advance the model at the edge.
    task automatic step(input string tag, input logic vin, input logic [63:0] din,
                        input logic lin, input logic rdy);
        bit    acc;
        bit    pop;
        beat_t b;
        s_tvalid = vin;
        s_tdata  = din;
        s_tlast  = lin;
        m_tready = rdy;
        @(negedge clk);
        check_model(tag);
        acc = vin && ready_ok && (model.size() < CAP);
        pop = (model.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(model.pop_front());
        end
        if (acc) begin
            b.tdata = din;
            b.tlast = lin;
            model.push_back(b);
        end
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        #3;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        chk({tag, "_rst_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_rst_tready"}, 64'(s_tready), 64'd0);
        chk({tag, "_rst_level"}, 64'(level), 64'd0);
        chk({tag, "_rst_afull"}, 64'(almost_full), 64'd0);
        chk({tag, "_rst_tdata"}, m_tdata, 64'd0);
        chk({tag, "_rst_tlast"}, 64'(m_tlast), 64'd0);
`ifdef PACKET_FIFO_DROP_CNT_EN
        chk({tag, "_rst_drop"}, 64'(drop_count), 64'd0);
`endif
        model.delete();
        ready_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_hold_tready"}, 64'(s_tready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ready_ok = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("init");

        // Single beat with immediate drain.
        step("single_wr", 1'b1, 64'h0000_0000_0000_0901, 1'b1, 1'b1);
        step("single_out", 1'b0, 64'd0, 1'b0, 1'b1);
        step("single_empty", 1'b0, 64'd0, 1'b0, 1'b1);

        // Fill to capacity with downstream stalled; the 18th beat must be refused.
        for (int i = 0; i < 18; i++) begin
            step("fill", 1'b1, 64'(i), 1'(i == 16), 1'b0);
        end
        step("fill_hold", 1'b1, 64'hDEAD, 1'b0, 1'b0);
        chk("fill_level_max", 64'(level), 64'(CAP));
        for (int i = 0; i < 19; i++) begin
            step("drain", 1'b0, 64'd0, 1'b0, 1'b1);
        end

        // Back-to-back streaming: one in, one out every cycle.
        for (int i = 0; i < 100; i++) begin
            step("stream", 1'b1, 64'h1000 + 64'(i), 1'(i % 7 == 6), 1'b1);
        end
        step("stream_tail", 1'b0, 64'd0, 1'b0, 1'b1);
        step("stream_end", 1'b0, 64'd0, 1'b0, 1'b1);

        // Random valid/ready with random payloads.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 1'($urandom % 2), 1'($urandom % 2));
        end

        // Load some beats, then reset mid-stream: everything is discarded.
        for (int i = 0; i < 6; i++) begin
            step("pre_rst", 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        end
        do_reset("mid");
        step("post_rst", 1'b0, 64'd0, 1'b0, 1'b1);
        step("post_rst_wr", 1'b1, 64'hABCD, 1'b1, 1'b0);
        step("post_rst_out", 1'b0, 64'd0, 1'b0, 1'b1);
        step("post_rst_end", 1'b0, 64'd0, 1'b0, 1'b1);

`ifdef PACKET_FIFO_DROP_CNT_EN
        do_reset("drop");
        for (int i = 0; i < CAP; i++) begin
            step("drop_fill", 1'b1, 64'(i), 1'b0, 1'b0);
        end
        chk("drop_before", 64'(drop_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step("drop_refuse", 1'b1, 64'hFFFF, 1'b0, 1'b0);
        end
        chk("drop_count5", 64'(drop_count), 64'd5);
        do_reset("drop_clr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
